// File: rtl/matrix_scan.sv
// matrix_scan: 16x16 LED matrix scanner driving a column shift register
// (CCLK/CSDI/LE), a row walking-token shift register (RCLK/RSDI) and a
// display enable (OEB, active low). Each row is shifted, the row token
// advanced, the columns latched, and then the row is displayed for DWELL cycles.
// Optional build macro MATRIX_DBUF_EN: front/back frame buffers with a
// swap request that is honoured at frame end (or at once when idle).
module matrix_scan #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned DWELL   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic       wr_data,
  input  logic       swap,
  output logic       RCLK,
  output logic       RSDI,
  output logic       CCLK,
  output logic       CSDI,
  output logic       LE,
  output logic       OEB,
  output logic       frame_done
);

  localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] DW_LAST = 8'(DWELL - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    ROWCLK,
    LATCH,
    DISPLAY
  } state_t;

  state_t      state;
  logic [3:0]  row;
  logic [3:0]  bitn;
  logic [7:0]  cnt;
  logic        half;
  logic [15:0] snap;

  logic        phase_end;
  logic        frame_end;
  logic [3:0]  load_row;
  logic [15:0] load_bits;

  // Phase/row boundary decodes and the row that the next SHIFT will snapshot.
  always_comb begin
    phase_end = (cnt == PH_LAST);
    frame_end = (state == DISPLAY) && (cnt == DW_LAST) && (row == 4'd15);
    load_row  = (state == DISPLAY) ? row + 4'd1 : '0;
  end

`ifdef MATRIX_DBUF_EN
  logic [15:0] fb [2][16];
  logic        front;
  logic        pending;
  logic        swap_now;

  // Exchange when idle (including a swap arriving now) or at frame end if one is pending.
  always_comb begin
    swap_now = (state == IDLE) ? (pending | swap) : (pending & frame_end);
  end

  // Writes land in the back buffer; front flips on exchange, pending tracks requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb      <= '{default: '0};
      front   <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (wr_en) fb[~front][wr_addr[7:4]][wr_addr[3:0]] <= wr_data;
      if (swap_now) front <= ~front;
      // A swap seen on the exchange edge itself waits for the following frame end.
      pending <= (pending & ~swap_now) | (swap & (state != IDLE));
    end
  end

  // Snapshot source already reflects an exchange happening on the same edge.
  assign load_bits = fb[front ^ swap_now][load_row];
`else
  logic [15:0] fb [16];
  logic        unused_swap;

  assign unused_swap = swap;

  // Single buffer: writes go straight to the scanned pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb <= '{default: '0};
    end else if (wr_en) begin
      fb[wr_addr[7:4]][wr_addr[3:0]] <= wr_data;
    end
  end

  assign load_bits = fb[load_row];
`endif

  // Scan sequencer; every output is registered with the value for the coming cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      bitn       <= '0;
      cnt        <= '0;
      half       <= 1'b0;
      snap       <= '0;
      RCLK       <= 1'b0;
      RSDI       <= 1'b0;
      CCLK       <= 1'b0;
      CSDI       <= 1'b0;
      LE         <= 1'b0;
      OEB        <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          RCLK <= 1'b0;
          RSDI <= 1'b0;
          CCLK <= 1'b0;
          CSDI <= 1'b0;
          LE   <= 1'b0;
          OEB  <= 1'b1;
          cnt  <= '0;
          half <= 1'b0;
          bitn <= '0;
          row  <= '0;
          if (enable) begin
            state <= SHIFT;
            snap  <= load_bits;
            CSDI  <= load_bits[15];
          end
        end

        SHIFT: begin
          if (phase_end) begin
            cnt <= '0;
            if (!half) begin
              half <= 1'b1;
              CCLK <= 1'b1;
            end else if (bitn == 4'd15) begin
              half  <= 1'b0;
              CCLK  <= 1'b0;
              CSDI  <= 1'b0;
              RSDI  <= (row == 4'd0);
              state <= ROWCLK;
            end else begin
              // snap is MSB-first, so the next column is 14 - current bit index.
              half <= 1'b0;
              CCLK <= 1'b0;
              bitn <= bitn + 4'd1;
              CSDI <= snap[4'd14 - bitn];
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ROWCLK: begin
          if (phase_end) begin
            cnt <= '0;
            if (!half) begin
              half <= 1'b1;
              RCLK <= 1'b1;
            end else begin
              half  <= 1'b0;
              RCLK  <= 1'b0;
              RSDI  <= 1'b0;
              LE    <= 1'b1;
              state <= LATCH;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        LATCH: begin
          if (phase_end) begin
            cnt   <= '0;
            LE    <= 1'b0;
            OEB   <= 1'b0;
            state <= DISPLAY;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        DISPLAY: begin
          if (cnt == DW_LAST) begin
            cnt        <= '0;
            OEB        <= 1'b1;
            frame_done <= (row == 4'd15);
            if (enable) begin
              state <= SHIFT;
              row   <= row + 4'd1;
              snap  <= load_bits;
              CSDI  <= load_bits[15];
              half  <= 1'b0;
              bitn  <= '0;
            end else begin
              state <= IDLE;
              row   <= '0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan.sv
// Testbench for matrix_scan: per-cycle comparison against an offset-based
// model of the row timing, plus literal checks of counts and cycle positions.
module tb_matrix_scan;

  localparam int CD  = 2;
  localparam int DW  = 64;
  localparam int PER = 35 * CD + DW;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic       wr_data = 1'b0;
  logic       swap = 1'b0;
  logic       RCLK, RSDI, CCLK, CSDI, LE, OEB, frame_done;

  int checks = 0;
  int errors = 0;
  int nprint = 0;
  bit chk_on = 1'b0;

  matrix_scan #(.CLK_DIV(CD), .DWELL(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .swap(swap),
    .RCLK(RCLK), .RSDI(RSDI), .CCLK(CCLK), .CSDI(CSDI), .LE(LE),
    .OEB(OEB), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: running flag, row, cycle offset within the row and the row snapshot.
  bit          m_run, m_front, m_pend, m_fd, m_sw, m_wb;
  int          m_row, m_off, m_nr;
  logic [15:0] m_snap;
  logic [15:0] m_pix [2][16];

  always @(posedge clk) begin
    if (reset) begin
      m_run = 0; m_row = 0; m_off = 0; m_snap = '0;
      m_front = 0; m_pend = 0; m_fd = 0;
      for (int b = 0; b < 2; b++)
        for (int y = 0; y < 16; y++) m_pix[b][y] = '0;
    end else begin
      m_fd = 0;
      m_sw = 0;
`ifdef MATRIX_DBUF_EN
      m_wb = !m_front;
      if (!m_run) m_sw = m_pend || swap;
      else        m_sw = m_pend && (m_off == PER - 1) && (m_row == 15);
      m_pend = (m_sw ? 1'b0 : m_pend) | (swap && m_run);
      if (m_sw) m_front = !m_front;
`else
      m_wb = m_front;
`endif
      if (!m_run) begin
        if (enable) begin
          m_run = 1; m_row = 0; m_off = 0; m_snap = m_pix[m_front][0];
        end
      end else if (m_off == PER - 1) begin
        m_fd = (m_row == 15);
        m_nr = (m_row + 1) % 16;
        if (enable) begin
          m_row = m_nr; m_off = 0; m_snap = m_pix[m_front][m_nr];
        end else begin
          m_run = 0; m_row = 0; m_off = 0;
        end
      end else begin
        m_off++;
      end
      if (wr_en) m_pix[m_wb][wr_addr[7:4]][wr_addr[3:0]] = wr_data;
    end
  end

  // Per-cycle compare of all outputs against the model.
  logic [6:0] exp_v, got_v;
  always @(negedge clk) begin
    if (chk_on) begin
      exp_v = 7'b0000010;
      if (m_run) begin
        if (m_off < 32 * CD) begin
          exp_v[4] = (m_off % (2 * CD)) >= CD;
          exp_v[3] = m_snap[15 - m_off / (2 * CD)];
        end else if (m_off < 34 * CD) begin
          exp_v[5] = (m_row == 0);
          exp_v[6] = (m_off - 32 * CD) >= CD;
        end else if (m_off < 35 * CD) begin
          exp_v[2] = 1'b1;
        end else begin
          exp_v[1] = 1'b0;
        end
      end
      exp_v[0] = m_fd;
      got_v = {RCLK, RSDI, CCLK, CSDI, LE, OEB, frame_done};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        if (nprint < 30)
          $display("FAIL outputs t=%0t {RCLK,RSDI,CCLK,CSDI,LE,OEB,fd} got %b expected %b",
                   $time, got_v, exp_v);
        nprint++;
      end
    end
  end

  logic [15:0] cap [32];
  logic [15:0] seq;
  bit          prev_cclk;
  int rise_r0, le_r0, oeb_r0, rclk_r0, rs_r0, first_rise_r1, fd_first, fd_cnt;
  int rs_mid, rs_f2, overlap, oeb_r3, cclk_after, oeb_after, rclk_b, rs_b;

  initial begin
    for (int k = 0; k < 32; k++) cap[k] = '0;
    rise_r0 = 0; le_r0 = 0; oeb_r0 = 0; rclk_r0 = 0; rs_r0 = 0;
    first_rise_r1 = -1; fd_first = -1; fd_cnt = 0;
    rs_mid = 0; rs_f2 = 0; overlap = 0;

    // Phase A: reset, one full frame plus three rows
    @(negedge clk);
    chk_on = 1'b1;
    check("reset_outputs", int'({RCLK, RSDI, CCLK, CSDI, LE, OEB, frame_done}), 7'b0000010);
    reset = 1'b0;
    @(negedge clk);
    check("idle_oeb", int'(OEB), 1);
    enable = 1'b1;
    prev_cclk = 1'b0;
    for (int i = 0; i < 2600; i++) begin
      @(negedge clk);
      if (CCLK && !prev_cclk) begin
        cap[i / PER] = {cap[i / PER][14:0], CSDI};
        if (i < PER) rise_r0++;
        if (i >= PER && first_rise_r1 < 0) first_rise_r1 = i;
      end
      prev_cclk = CCLK;
      if (i < PER) begin
        if (LE) le_r0++;
        if (!OEB) oeb_r0++;
        if (RCLK) rclk_r0++;
        if (RCLK && RSDI) rs_r0++;
      end
      if (i >= PER && i < 16 * PER && RCLK && RSDI) rs_mid++;
      if (i >= 16 * PER && i < 17 * PER && RCLK && RSDI) rs_f2++;
      if (frame_done) begin
        fd_cnt++;
        if (fd_first < 0) fd_first = i;
      end
      if (int'(RCLK) + int'(CCLK) + int'(LE) > 1) overlap++;
      case (i)
        133: begin wr_en = 1; wr_addr = 8'h15; wr_data = 1; end
        134: wr_en = 0;
        300: begin wr_en = 1; wr_addr = 8'h0F; wr_data = 1; end
        301: wr_addr = 8'h00;
        302: wr_addr = 8'h22;
        303: wr_en = 0;
        310: swap = 1;
        311: swap = 0;
        default: ;
      endcase
    end
    check("row0_cclk_pulses", rise_r0, 16);
    check("row0_csdi_bits", int'(cap[0]), 0);
    check("row0_rclk_cycles", rclk_r0, 2);
    check("row0_rsdi_during_rclk", rs_r0, 2);
    check("row0_le_cycles", le_r0, 2);
    check("row0_oeb_low_cycles", oeb_r0, 64);
    check("row1_first_cclk_rise", first_rise_r1, 136);
    check("frame_done_cycle", fd_first, 2144);
    check("frame_done_count", fd_cnt, 1);
    check("rows1_15_rsdi", rs_mid, 0);
    check("frame2_row0_rsdi", rs_f2, 2);
    check("clk_overlap", overlap, 0);
    check("row1_same_cycle_write_hidden", int'(cap[1]), 0);
    check("row2_late_write_hidden", int'(cap[2]), 0);
    check("frame2_row0_bits", int'(cap[16]), 16'h8001);
    check("frame2_row1_bits", int'(cap[17]), 16'h0020);
    check("frame2_row2_bits", int'(cap[18]), 16'h0004);

    // Phase B: enable dropped at cycle 10 of row 3
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;
    oeb_r3 = 0; cclk_after = 0; oeb_after = 0;
    for (int i = 0; i < 736; i++) begin
      @(negedge clk);
      if (i >= 3 * PER && i < 4 * PER && !OEB) oeb_r3++;
      if (i >= 4 * PER) begin
        if (CCLK) cclk_after++;
        if (!OEB) oeb_after++;
      end
      if (i == 3 * PER + 10) enable = 1'b0;
    end
    check("row3_completes_oeb_low", oeb_r3, 64);
    check("idle_no_cclk", cclk_after, 0);
    check("idle_oeb_high", oeb_after, 0);
    enable = 1'b1;
    rclk_b = 0; rs_b = 0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      if (RCLK) rclk_b++;
      if (RCLK && RSDI) rs_b++;
    end
    check("restart_row0_rclk", rclk_b, 2);
    check("restart_row0_rsdi", rs_b, 2);

    // Phase C: reset during SHIFT clears outputs and pixels
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j == 0) begin wr_en = 1; wr_addr = 8'h07; wr_data = 1; end
      if (j == 1) wr_en = 0;
      if (j == 19) reset = 1'b1;
    end
    @(negedge clk);
    check("midshift_reset_outputs", int'({RCLK, RSDI, CCLK, CSDI, LE, OEB, frame_done}), 7'b0000010);
    reset = 1'b0;
    seq = '0;
    prev_cclk = 1'b0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      if (CCLK && !prev_cclk) seq = {seq[14:0], CSDI};
      prev_cclk = CCLK;
    end
    check("after_reset_row0_bits", int'(seq), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
